// File: rtl/demux_12_pair_if.sv
// ----------------------------------------------------------------------------
// demux_12_pair_if
// Purpose : Bundles the serial word input and the paired-lane outputs of
//           demux_12_pair into one port.
// Signals : data_in   [WIDTH] serial word, qualified by valid_in
//           valid_in  [1]     one word per cycle maximum
//           data_out0 [WIDTH] lane-0 word of the last completed pair
//           data_out1 [WIDTH] lane-1 word of the last completed pair
//           valid_out [1]     one-cycle pulse: a new pair was presented
//           orphan    [1]     one-cycle pulse: held lane-0 word timed out
//           lane      [1]     lane the next accepted word goes to
//           act_cnt   [16]    switching-activity count (DEMUX_ACTIVITY_CNT_EN)
// Modports: master = word source / pair consumer side, slave = demux.
// Options : DEMUX_ACTIVITY_CNT_EN adds act_cnt.
// ----------------------------------------------------------------------------
interface demux_12_pair_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_out0;
    logic [WIDTH-1:0] data_out1;
    logic             valid_out;
    logic             orphan;
    logic             lane;
`ifdef DEMUX_ACTIVITY_CNT_EN
    logic [15:0]      act_cnt;

    modport master (
        output data_in, valid_in,
        input  data_out0, data_out1, valid_out, orphan, lane, act_cnt
    );

    modport slave (
        input  data_in, valid_in,
        output data_out0, data_out1, valid_out, orphan, lane, act_cnt
    );
`else
    modport master (
        output data_in, valid_in,
        input  data_out0, data_out1, valid_out, orphan, lane
    );

    modport slave (
        input  data_in, valid_in,
        output data_out0, data_out1, valid_out, orphan, lane
    );
`endif
endinterface

// File: rtl/demux_12_pair.sv
// ----------------------------------------------------------------------------
// demux_12_pair
// Purpose : Receive-side 1:2 demux. Alternate accepted words are steered to
//           lane 0 and lane 1; each completed pair is presented on
//           data_out0/data_out1 with a one-cycle valid_out pulse. A lane-0
//           word left unpaired for TIMEOUT idle cycles is dropped and flagged
//           with a one-cycle orphan pulse.
// Ports   : clk    - single clock, posedge
//           Reset  - synchronous, active-high reset
//           bus    - demux_12_pair_if.slave (data_in, valid_in in;
//                    data_out0, data_out1, valid_out, orphan, lane out)
// Params  : WIDTH   - word width
//           TIMEOUT - idle cycles tolerated in HALF; 0 waits forever
// Options : DEMUX_ACTIVITY_CNT_EN adds bus.act_cnt, a saturating 16-bit sum
//           of output bit toggles per presented pair.
// ----------------------------------------------------------------------------
module demux_12_pair #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           Reset,
    demux_12_pair_if.slave bus
);

    // Idle counter sized to hold TIMEOUT; one bit minimum when disabled.
    localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HALF = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_dout0;
    logic [WIDTH-1:0] w_dout0_nxt;
    logic [WIDTH-1:0] r_dout1;
    logic [WIDTH-1:0] w_dout1_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_orphan;
    logic             w_orphan_nxt;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_cnt    <= '0;
            r_dout0  <= '0;
            r_dout1  <= '0;
            r_valid  <= 1'b0;
            r_orphan <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dout0  <= w_dout0_nxt;
            r_dout1  <= w_dout1_nxt;
            r_valid  <= w_valid_nxt;
            r_orphan <= w_orphan_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_cnt_nxt    = r_cnt;
        w_dout0_nxt  = r_dout0;
        w_dout1_nxt  = r_dout1;
        w_valid_nxt  = 1'b0;
        w_orphan_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.valid_in) begin
                    w_hold_nxt  = bus.data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HALF;
                end
            end
            S_HALF: begin
                // A partner word wins over a simultaneous timeout expiry.
                if (bus.valid_in) begin
                    w_dout0_nxt = r_hold;
                    w_dout1_nxt = bus.data_in;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (TO_EN) begin
                    if (r_cnt == CNT_LAST) begin
                        // Held word is abandoned in place, not cleared.
                        w_orphan_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.data_out0 = r_dout0;
    assign bus.data_out1 = r_dout1;
    assign bus.valid_out = r_valid;
    assign bus.orphan    = r_orphan;
    assign bus.lane      = r_state;

`ifdef DEMUX_ACTIVITY_CNT_EN
    localparam int unsigned POP_W = $clog2(WIDTH + 1);

    logic [15:0] r_act_cnt;
    logic [16:0] w_act_sum;
    logic [15:0] w_act_nxt;

    function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [POP_W-1:0] s;
        s = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s = s + POP_W'(v[i]);
        end
        return s;
    endfunction

    // Output toggles are zero unless a pair is being presented.
    always_comb begin
        w_act_sum = {1'b0, r_act_cnt}
                  + 17'(popcount(r_dout0 ^ w_dout0_nxt))
                  + 17'(popcount(r_dout1 ^ w_dout1_nxt));
        w_act_nxt = w_act_sum[16] ? 16'hFFFF : w_act_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_act_cnt <= '0;
        end else begin
            r_act_cnt <= w_act_nxt;
        end
    end

    assign bus.act_cnt = r_act_cnt;
`endif

endmodule

// File: tb/tb_demux_12_pair.sv
// ----------------------------------------------------------------------------
// tb_demux_12_pair
// Purpose : Self-checking bench for demux_12_pair (WIDTH=8, TIMEOUT=4).
//           Expected pairs are queued when the lane-1 word is driven and
//           compared when valid_out pulses. Exercises the activity counter
//           when DEMUX_ACTIVITY_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_demux_12_pair;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 4;

    typedef struct packed {
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
    } pair_t;

    logic  clk = 1'b0;
    logic  Reset;
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    n_valid  = 0;
    int    n_orphan = 0;
    pair_t exp_q[$];

    always #5 clk = ~clk;

    demux_12_pair_if #(.WIDTH(WIDTH)) bus ();

    demux_12_pair #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of input and return just after the sampling edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d);
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic push(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        pair_t p;
        p.d0 = d0;
        p.d1 = d1;
        exp_q.push_back(p);
    endtask

    // Scoreboard side: pop and compare on every valid_out pulse.
    always @(negedge clk) begin
        pair_t p;
        if (!Reset) begin
            check_eq("valid_orphan_excl", 32'(bus.valid_out & bus.orphan), 0);
            if (bus.orphan) n_orphan++;
            if (bus.valid_out) begin
                n_valid++;
                check_eq("pair_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    check_eq("data_out0", 32'(bus.data_out0), 32'(p.d0));
                    check_eq("data_out1", 32'(bus.data_out1), 32'(p.d1));
                end
            end
        end
    end

    initial begin
        // Reset overrides an active input.
        Reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_data_out0", 32'(bus.data_out0), 0);
        check_eq("rst_data_out1", 32'(bus.data_out1), 0);
        check_eq("rst_valid_out", 32'(bus.valid_out), 0);
        check_eq("rst_orphan",    32'(bus.orphan), 0);
        check_eq("rst_lane",      32'(bus.lane), 0);
        Reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        idle(3);
        check_eq("rst_no_valid", 32'(n_valid), 0);
        check_eq("rst_lane_idle", 32'(bus.lane), 0);

        // Back-to-back stream.
        check_eq("b2b_lane_a", 32'(bus.lane), 0);
        step(1'b1, 8'h11);
        check_eq("b2b_lane_b", 32'(bus.lane), 1);
        push(8'h11, 8'h22);
        step(1'b1, 8'h22);
        check_eq("b2b_lat1", 32'(bus.valid_out), 1);
        check_eq("b2b_lane_c", 32'(bus.lane), 0);
        step(1'b1, 8'h33);
        check_eq("b2b_pulse_end", 32'(bus.valid_out), 0);
        check_eq("b2b_lane_d", 32'(bus.lane), 1);
        push(8'h33, 8'h44);
        step(1'b1, 8'h44);
        check_eq("b2b_lat2", 32'(bus.valid_out), 1);
        check_eq("b2b_out0", 32'(bus.data_out0), 32'h33);
        idle(2);
        check_eq("b2b_count", 32'(n_valid), 2);

        // Gapped pair within the timeout window.
        step(1'b1, 8'hA5);
        idle(3);
        push(8'hA5, 8'h5A);
        step(1'b1, 8'h5A);
        check_eq("gap_valid", 32'(bus.valid_out), 1);
        check_eq("gap_orphan", 32'(bus.orphan), 0);
        idle(2);

        // Timeout drops the held word.
        step(1'b1, 8'hC3);
        idle(3);
        check_eq("to_not_yet", 32'(bus.orphan), 0);
        check_eq("to_lane_half", 32'(bus.lane), 1);
        idle(1);
        check_eq("to_orphan", 32'(bus.orphan), 1);
        check_eq("to_lane_idle", 32'(bus.lane), 0);
        check_eq("to_keep0", 32'(bus.data_out0), 32'hA5);
        check_eq("to_keep1", 32'(bus.data_out1), 32'h5A);
        idle(1);
        check_eq("to_pulse_end", 32'(bus.orphan), 0);
        step(1'b1, 8'h01);
        push(8'h01, 8'h02);
        step(1'b1, 8'h02);
        check_eq("to_after_pair", 32'(bus.valid_out), 1);
        idle(2);
        check_eq("to_orphan_count", 32'(n_orphan), 1);

        // Partner arriving exactly on the expiry cycle wins.
        step(1'b1, 8'h10);
        idle(3);
        push(8'h10, 8'h20);
        step(1'b1, 8'h20);
        check_eq("edge_valid", 32'(bus.valid_out), 1);
        check_eq("edge_orphan", 32'(bus.orphan), 0);
        idle(6);
        check_eq("edge_lane", 32'(bus.lane), 0);

        // Reset while holding a lane-0 word.
        step(1'b1, 8'h77);
        Reset = 1'b1;
        step(1'b0, '0);
        Reset = 1'b0;
        check_eq("mid_rst_lane", 32'(bus.lane), 0);
        check_eq("mid_rst_out0", 32'(bus.data_out0), 0);
        step(1'b1, 8'h01);
        push(8'h01, 8'h02);
        step(1'b1, 8'h02);
        check_eq("mid_rst_valid", 32'(bus.valid_out), 1);
        idle(6);
        check_eq("mid_rst_orphan", 32'(n_orphan), 1);

`ifdef DEMUX_ACTIVITY_CNT_EN
        Reset = 1'b1;
        step(1'b0, '0);
        Reset = 1'b0;
        check_eq("act_rst", 32'(bus.act_cnt), 0);
        push(8'h00, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        push(8'hFF, 8'h0F);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h0F);
        idle(1);
        check_eq("act_12", 32'(bus.act_cnt), 12);
        for (int k = 0; k < 6000; k++) begin
            logic [WIDTH-1:0] w;
            w = (k % 2 == 0) ? 8'hFF : 8'h00;
            step(1'b1, w);
            push(w, w);
            step(1'b1, w);
        end
        idle(2);
        check_eq("act_sat", 32'(bus.act_cnt), 32'hFFFF);
`endif

        idle(2);
        check_eq("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
